// File: rtl/vga_rect_writer_pkg.sv
// rtl/vga_rect_writer_pkg.sv - shared states, geometry defaults and widths for the rectangle filler
package vga_rect_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int HSIZE_DEF = 320;
  localparam int VSIZE_DEF = 240;
  localparam int COLOR_W   = 12;
  localparam int COORD_W   = 10;

endpackage

// File: rtl/vga_rect_writer_scan.sv
// rtl/vga_rect_writer_scan.sv - raster x/y counter (module vga_rect_scan) with last-pixel flag
module vga_rect_scan
  import vga_rect_writer_pkg::*;
(
  input  logic               rclk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] haddr,
  output logic [COORD_W-1:0] vaddr,
  output logic               last
);

  assign last = (haddr == x1) && (vaddr == y1);

  // The owner never steps past the last pixel, so y cannot run beyond y1.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      haddr <= '0;
      vaddr <= '0;
    end else if (load) begin
      haddr <= ld_x;
      vaddr <= ld_y;
    end else if (step) begin
      if (haddr == x1) begin
        haddr <= x0;
        vaddr <= vaddr + 1'b1;
      end else begin
        haddr <= haddr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_writer.sv
// rtl/vga_rect_writer.sv - solid rectangle framebuffer filler with one-cycle address lead
// Optional clipping to HSIZE x VSIZE is enabled by defining VGA_RECT_CLIP_EN.
module vga_rect_writer
  import vga_rect_writer_pkg::*;
#(
  parameter int HSIZE = HSIZE_DEF,
  parameter int VSIZE = VSIZE_DEF
) (
  input  logic               rclk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               we,
  output logic [COORD_W-1:0] haddr,
  output logic [COORD_W-1:0] vaddr,
  output logic [COLOR_W-1:0] wdata,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x0_q, x1_q, y1_q;
  logic [COLOR_W-1:0] color_q;
  logic [COORD_W-1:0] x1_eff, y1_eff;
  logic               wr_last, wr_last_nxt;
  logic               accept, empty, load, step, scan_last;

  assign accept = (state == IDLE) && cmd_ready && cmd_valid;

`ifdef VGA_RECT_CLIP_EN
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(HSIZE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(VSIZE - 1);

  // Clamped far corner already bounds the origin: x0 >= HSIZE implies x0 > x1_eff.
  always_comb begin
    x1_eff = (cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
    y1_eff = (cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
    empty  = (cmd_x0 > x1_eff) || (cmd_y0 > y1_eff);
  end
`else
  always_comb begin
    x1_eff = cmd_x1;
    y1_eff = cmd_y1;
    empty  = (cmd_x0 > x1_eff) || (cmd_y0 > y1_eff);
  end
`endif

  // wr_last flags that the pixel being written this cycle is the final one.
  always_comb begin
    state_nxt   = state;
    wr_last_nxt = wr_last;
    load        = 1'b0;
    step        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load      = !empty;
          state_nxt = empty ? FIN : PREP;
        end
      end
      PREP: begin
        if (abort) begin
          state_nxt = FIN;
        end else begin
          state_nxt   = WRITE;
          wr_last_nxt = scan_last;
          step        = !scan_last;
        end
      end
      WRITE: begin
        if (abort || wr_last) begin
          state_nxt = FIN;
        end else begin
          wr_last_nxt = scan_last;
          step        = !scan_last;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      wr_last   <= 1'b0;
      x0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      wr_last   <= wr_last_nxt;
      if (accept) begin
        x0_q    <= cmd_x0;
        x1_q    <= x1_eff;
        y1_q    <= y1_eff;
        color_q <= cmd_color;
      end
    end
  end

  vga_rect_scan u_scan (
    .rclk  (rclk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .ld_x  (cmd_x0),
    .ld_y  (cmd_y0),
    .x0    (x0_q),
    .x1    (x1_q),
    .y1    (y1_q),
    .haddr (haddr),
    .vaddr (vaddr),
    .last  (scan_last)
  );

  assign we    = (state == WRITE);
  assign done  = (state == FIN);
  assign busy  = (state != IDLE);
  assign wdata = color_q;

endmodule

// File: doc/vga_rect_writer.md
VGA_RECT_WRITER -- requirements
Module: vga_rect_writer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  HSIZE, 320, framebuffer width in pixels
  VSIZE, 240, framebuffer height in pixels
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  rclk  in  1  clock, all logic on rising edge
  rst  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  fill command offered
  cmd_ready  out  1  command accepted when both high at rising edge
  cmd_x0, cmd_y0  in  10 each  top-left corner, inclusive
  cmd_x1, cmd_y1  in  10 each  bottom-right corner, inclusive
  cmd_color  in  12  RGB444 fill colour {R,G,B}
  abort  in  1  terminate current fill
  we  out  1  framebuffer write strobe
  haddr  out  10  framebuffer column
  vaddr  out  10  framebuffer row
  wdata  out  12  pixel data
  busy  out  1  fill in progress
  done  out  1  one-cycle completion pulse

Function
REQ-003 States SHALL be IDLE, PREP, WRITE, FIN; busy SHALL equal (state != IDLE).
REQ-004 cmd_ready SHALL be registered and high only in IDLE; command fields SHALL be captured on acceptance, and inputs SHALL be ignored at all other times.
REQ-005 An accepted command SHALL be empty if cmd_x0>cmd_x1 or cmd_y0>cmd_y1; an empty command SHALL go IDLE->FIN with no writes.
REQ-006 A non-empty command SHALL go IDLE->PREP. In PREP, haddr/vaddr SHALL present (x0,y0) with we=0.
REQ-007 Address lead: haddr/vaddr for pixel n SHALL be valid one cycle before the cycle in which we=1 and wdata carry pixel n.
REQ-008 In WRITE, we SHALL be 1 and wdata SHALL equal the captured colour every cycle, one pixel per cycle, with no gaps.
REQ-009 Scan order SHALL be raster: x increments x0..x1, then wraps to x0 while y increments, y0..y1.
REQ-010 Write count SHALL be exactly (x1-x0+1)*(y1-y0+1). Counters SHALL be 10 bits wide with no overflow possible.
REQ-011 After the last pixel is issued, haddr/vaddr SHALL hold the last pixel's value. The cycle after the last we=1 SHALL be FIN, with done=1 and we=0; the next state SHALL be IDLE.
REQ-012 Latency SHALL be as follows: acceptance at edge T gives PREP in cycle T+1, the first we=1 in cycle T+2, and done in cycle T+2+N for N pixels.
REQ-013 abort high at a rising edge in PREP or WRITE SHALL complete any write in that cycle, then enter FIN: we=0 and done=1 the next cycle. abort SHALL have no effect in IDLE or FIN.
REQ-014 A command offered in FIN SHALL NOT be accepted; cmd_ready SHALL rise in the cycle after done.
REQ-015 we SHALL be 0 whenever state != WRITE.

Reset
REQ-016 rst low SHALL force, asynchronously: state=IDLE, cmd_ready=0, we=0, haddr=0, vaddr=0, wdata=0, busy=0, done=0.
REQ-017 cmd_ready SHALL become 1 at the first rising edge after rst deasserts. A fill interrupted by reset SHALL be discarded with no further writes.

Configuration
REQ-018 With VGA_RECT_CLIP_EN defined, at acceptance:
  x1 SHALL be clamped to HSIZE-1 and y1 to VSIZE-1;
  x0>=HSIZE or y0>=VSIZE SHALL make the command empty.
REQ-019 Without VGA_RECT_CLIP_EN, coordinates SHALL be used unmodified, and out-of-range addresses SHALL be issued as-is.

Structure
REQ-020 A shared package SHALL hold the state enumeration, the HSIZE/VSIZE defaults (320/240), and the colour width constant (12).
REQ-021 One sub-module, vga_rect_scan (the x/y raster counter with last-pixel flag), SHALL be instantiated; the FSM and handshake SHALL stay in the top module.

Verification
REQ-022 Fill (2,3)-(4,4), colour 12'hF00 -> exactly 6 we pulses in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), each with wdata=F00, each address one cycle ahead of its we; done 8 cycles after acceptance.
REQ-023 Single pixel (0,0)-(0,0), colour 12'h0F0 -> one write, then done the following cycle; cmd_ready high the cycle after done.
REQ-024 Empty (5,0)-(4,0) -> zero writes, done one cycle after acceptance.
REQ-025 Full-screen (0,0)-(319,239) with abort asserted at the 100th write cycle -> exactly 100 writes, we=0 and done=1 the next cycle.
REQ-026 VGA_RECT_CLIP_EN, (318,238)-(400,300) -> 4 writes, to (318,238),(319,238),(318,239),(319,239); with (320,0)-(330,5) -> zero writes, done pulse.
REQ-027 rst low mid-fill -> all outputs 0 immediately; after release, no writes until a new command; cmd_ready=1 after the first edge.
